// File: rtl/pio_cfg_loader.sv
// pio_cfg_loader
//   Buffers a PIO program plus one machine's configuration, then on a start
//   request replays it onto the pio command bus in the order
//   instructions -> wrap -> clock divider -> pin groups -> enable.
//   Each command is held on the bus for HOLD cycles. All bus outputs are
//   registered, so index/din/mindex keep their last value when not driven.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   prog_we/addr/wdata    program buffer write port (accepted in IDLE only)
//   plen                  program length in words (clamped to PROG_MAX)
//   mindex_cfg, wrap_cfg  target machine and wrap-top index
//   div_cfg               16.8 clock divider
//   pin_grps_cfg, en_cfg  packed pin groups, machine enable mask
//   start                 begin a load (sampled in IDLE only)
//   busy, done            sequence in progress / one-cycle end pulse
//   action,index,mindex,din  pio command bus
module pio_cfg_loader #(
  parameter int HOLD     = 2,
  parameter int PROG_MAX = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_we,
  input  logic [4:0]  prog_addr,
  input  logic [15:0] prog_wdata,
  input  logic [5:0]  plen,
  input  logic [1:0]  mindex_cfg,
  input  logic [4:0]  wrap_cfg,
  input  logic [23:0] div_cfg,
  input  logic [31:0] pin_grps_cfg,
  input  logic [3:0]  en_cfg,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [3:0] A_NONE  = 4'd0;
  localparam logic [3:0] A_INSTR = 4'd1;
  localparam logic [3:0] A_WRAP  = 4'd2;
  localparam logic [3:0] A_PINS  = 4'd5;
  localparam logic [3:0] A_EN    = 4'd6;
  localparam logic [3:0] A_DIV   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_INSTR, S_WRAP, S_DIV, S_PINS, S_EN, S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [4:0]     k_q, k_d;

  // captured configuration
  logic [5:0]     plen_q;
  logic [1:0]     mcfg_q;
  logic [4:0]     wrap_q;
  logic [23:0]    div_q;
  logic [31:0]    pins_q;
  logic [3:0]     en_q;

  // registered outputs
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [3:0]     action_q, action_d;
  logic [4:0]     index_q, index_d;
  logic [1:0]     mindex_q, mindex_d;
  logic [31:0]    din_q, din_d;

  logic [15:0]    mem_q [PROG_MAX];
  logic [15:0]    rdata_q;
  logic [4:0]     rd_addr;

  logic           idle, cap, wr_en, hold_end, last_word, new_cmd;
  logic [5:0]     plen_clamp;
  logic [1:0]     mcfg_eff;
  logic [4:0]     wrap_eff;

  assign idle       = (state_q == S_IDLE);
  assign cap        = idle && start;
  assign wr_en      = idle && prog_we;
  assign plen_clamp = (plen > 6'(PROG_MAX)) ? 6'(PROG_MAX) : plen;
  assign hold_end   = (hcnt_q == HW'(HOLD - 1));
  assign last_word  = ({1'b0, k_q} == (plen_q - 6'd1));

  // With plen=0 the start edge goes straight to WRAP, before the captured
  // registers have been loaded, so take those fields from the inputs then.
  assign mcfg_eff = idle ? mindex_cfg : mcfg_q;
  assign wrap_eff = idle ? wrap_cfg   : wrap_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[prog_addr] <= prog_wdata;
  end

  // Prefetch: the word after the one being driven is always ready in
  // rdata_q, so word steps need no read bubble. A same-edge write to the
  // prefetch address is forwarded.
  assign rd_addr = (state_d == S_INSTR) ? (k_d + 5'd1) : 5'd0;

  always_ff @(posedge clk) begin
    rdata_q <= (wr_en && (prog_addr == rd_addr)) ? prog_wdata : mem_q[rd_addr];
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    action_d = action_q;
    index_d  = index_q;
    mindex_d = mindex_q;
    din_d    = din_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (plen_clamp == 6'd0) ? S_WRAP : S_INSTR;
          hcnt_d  = '0;
          k_d     = '0;
        end
      end
      S_INSTR: begin
        if (hold_end) begin
          hcnt_d = '0;
          if (last_word) state_d = S_WRAP;
          else           k_d     = k_q + 5'd1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_WRAP, S_DIV, S_PINS, S_EN: begin
        if (hold_end) begin
          hcnt_d = '0;
          case (state_q)
            S_WRAP:  state_d = S_DIV;
            S_DIV:   state_d = S_PINS;
            S_PINS:  state_d = S_EN;
            default: state_d = S_FIN;
          endcase
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // a fresh command (new state or next instruction word) loads the bus
    new_cmd = (state_d != state_q) || ((state_q == S_INSTR) && hold_end);

    case (state_d)
      S_IDLE: begin
        busy_d   = 1'b0;
        action_d = A_NONE;
      end
      S_INSTR: begin
        busy_d   = 1'b1;
        action_d = A_INSTR;
        if (new_cmd) begin
          index_d = k_d;
          din_d   = {16'b0, rdata_q};
        end
      end
      S_WRAP: begin
        busy_d   = 1'b1;
        action_d = A_WRAP;
        mindex_d = mcfg_eff;
        index_d  = wrap_eff;
      end
      S_DIV: begin
        busy_d   = 1'b1;
        action_d = A_DIV;
        din_d    = {8'b0, div_q};
      end
      S_PINS: begin
        busy_d   = 1'b1;
        action_d = A_PINS;
        din_d    = pins_q;
      end
      S_EN: begin
        busy_d   = 1'b1;
        action_d = A_EN;
        din_d    = {28'b0, en_q};
      end
      S_FIN: begin
        busy_d   = 1'b1;
        action_d = A_NONE;
        done_d   = 1'b1;
      end
      default: begin
        busy_d   = 1'b0;
        action_d = A_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      k_q      <= '0;
      plen_q   <= '0;
      mcfg_q   <= '0;
      wrap_q   <= '0;
      div_q    <= '0;
      pins_q   <= '0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      action_q <= '0;
      index_q  <= '0;
      mindex_q <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      action_q <= action_d;
      index_q  <= index_d;
      mindex_q <= mindex_d;
      din_q    <= din_d;
      if (cap) begin
        plen_q <= plen_clamp;
        mcfg_q <= mindex_cfg;
        wrap_q <= wrap_cfg;
        div_q  <= div_cfg;
        pins_q <= pin_grps_cfg;
        en_q   <= en_cfg;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign action = action_q;
  assign index  = index_q;
  assign mindex = mindex_q;
  assign din    = din_q;

endmodule

// File: tb/tb_pio_cfg_loader.sv
// Bench for pio_cfg_loader: one HOLD=2 and one HOLD=1 instance share the
// buffer/config inputs; sel picks which one receives start and is observed.
// The reference model expands the configuration into the expected per-cycle
// bus sequence from the command-ordering rules.
module tb_pio_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic [5:0]  plen_v;
  logic [1:0]  mi_v;
  logic [4:0]  wrap_v;
  logic [23:0] div_v;
  logic [31:0] pins_v;
  logic [3:0]  en_v;
  logic        start_v;
  logic        sel;

  logic        busy2, done2, busy1, done1;
  logic [3:0]  act2, act1;
  logic [4:0]  idx2, idx1;
  logic [1:0]  mi2, mi1;
  logic [31:0] din2, din1;

  pio_cfg_loader #(.HOLD(2), .PROG_MAX(32)) u_h2 (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .plen(plen_v), .mindex_cfg(mi_v), .wrap_cfg(wrap_v),
    .div_cfg(div_v), .pin_grps_cfg(pins_v), .en_cfg(en_v), .start(start_v & ~sel),
    .busy(busy2), .done(done2), .action(act2), .index(idx2), .mindex(mi2), .din(din2)
  );

  pio_cfg_loader #(.HOLD(1), .PROG_MAX(32)) u_h1 (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .plen(plen_v), .mindex_cfg(mi_v), .wrap_cfg(wrap_v),
    .div_cfg(div_v), .pin_grps_cfg(pins_v), .en_cfg(en_v), .start(start_v & sel),
    .busy(busy1), .done(done1), .action(act1), .index(idx1), .mindex(mi1), .din(din1)
  );

  logic        o_busy, o_done;
  logic [3:0]  o_act;
  logic [4:0]  o_idx;
  logic [1:0]  o_mi;
  logic [31:0] o_din;
  assign o_busy = sel ? busy1 : busy2;
  assign o_done = sel ? done1 : done2;
  assign o_act  = sel ? act1  : act2;
  assign o_idx  = sel ? idx1  : idx2;
  assign o_mi   = sel ? mi1   : mi2;
  assign o_din  = sel ? din1  : din2;

  typedef struct {
    logic [3:0]  a;
    logic [4:0]  ix;
    logic [1:0]  mi;
    logic [31:0] d;
    logic        dn;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mm [2][32];
  logic [4:0]  li [2];
  logic [31:0] ld [2];
  logic [1:0]  lm [2];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected bus contents for one full load of instance `inst`.
  function automatic void build(input int inst, input int h);
    int n = (plen_v > 6'd32) ? 32 : int'(plen_v);
    exp_t e;
    q.delete();
    e.ix = li[inst]; e.d = ld[inst]; e.mi = lm[inst]; e.dn = 1'b0;
    for (int k = 0; k < n; k++) begin
      e.a = 4'd1; e.ix = 5'(k); e.d = {16'b0, mm[inst][k]};
      for (int r = 0; r < h; r++) q.push_back(e);
    end
    e.a = 4'd2; e.mi = mi_v; e.ix = wrap_v;
    for (int r = 0; r < h; r++) q.push_back(e);
    e.a = 4'd7; e.d = {8'b0, div_v};
    for (int r = 0; r < h; r++) q.push_back(e);
    e.a = 4'd5; e.d = pins_v;
    for (int r = 0; r < h; r++) q.push_back(e);
    e.a = 4'd6; e.d = {28'b0, en_v};
    for (int r = 0; r < h; r++) q.push_back(e);
    e.a = 4'd0; e.dn = 1'b1;
    q.push_back(e);
    li[inst] = e.ix; ld[inst] = e.d; lm[inst] = e.mi;
  endfunction

  task automatic new_cfg();
    mi_v   = 2'($urandom);
    wrap_v = 5'($urandom);
    div_v  = 24'($urandom);
    pins_v = $urandom;
    en_v   = 4'($urandom);
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(posedge clk); @(negedge clk);
    prog_we = 1'b0;
    mm[0][a] = d; mm[1][a] = d;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_act"},  o_act,  0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_idx"},  o_idx,  0);
    chk({tag, "_mi"},   o_mi,   0);
    chk({tag, "_din"},  o_din,  0);
  endtask

  // Starts from a negedge with the selected instance idle.
  task automatic run_seq(input bit poke, input bit chain, input int rst_at);
    int inst = sel ? 1 : 0;
    int h    = sel ? 1 : 2;
    int n    = (plen_v > 6'd32) ? 32 : int'(plen_v);
    int bcnt = 0;
    int len;
    logic [4:0] pa;
    build(inst, h);
    len = q.size();
    start_v = 1'b1;
    @(posedge clk); @(negedge clk);
    start_v = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("act[%0d]", i),  o_act,  q[i].a);
      chk($sformatf("idx[%0d]", i),  o_idx,  q[i].ix);
      chk($sformatf("mi[%0d]", i),   o_mi,   q[i].mi);
      chk($sformatf("din[%0d]", i),  o_din,  q[i].d);
      chk($sformatf("done[%0d]", i), o_done, q[i].dn);
      chk($sformatf("busy[%0d]", i), o_busy, 1);
      if (o_busy) bcnt++;
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        chk_outs_zero("rst_mid");
        for (int j = 0; j < 2; j++) begin li[j] = '0; ld[j] = '0; lm[j] = '0; end
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk("post_rst_done", o_done, 0);
          chk("post_rst_busy", o_busy, 0);
          chk("post_rst_act",  o_act,  0);
        end
        return;
      end
      if (poke && i == 3) begin
        // ignored by the busy instance; the idle HOLD=1 instance takes the write
        pa = 5'($urandom_range(0, 3));
        start_v = 1'b1; prog_we = 1'b1; prog_addr = pa; prog_wdata = ~mm[0][pa];
        mm[1][pa] = ~mm[0][pa];
        plen_v = 6'($urandom_range(0, 40));
        new_cfg();
      end
      if (poke && i == 4) begin
        start_v = 1'b0; prog_we = 1'b0;
      end
      if (chain && i == len - 1) begin
        new_cfg();
        plen_v = 6'($urandom_range(0, 40));
        start_v = 1'b1;
      end
      @(negedge clk);
    end
    chk("idle_act",  o_act,  0);
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
    chk("idle_idx",  o_idx,  li[inst]);
    chk("idle_din",  o_din,  ld[inst]);
    chk("idle_mi",   o_mi,   lm[inst]);
    chk("busy_len",  bcnt,   (n + 4) * h + 1);
  endtask

  initial begin
    reset = 1'b1; start_v = 1'b0; sel = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    plen_v = '0; mi_v = '0; wrap_v = '0; div_v = '0; pins_v = '0; en_v = '0;
    for (int j = 0; j < 2; j++) begin li[j] = '0; ld[j] = '0; lm[j] = '0; end
    repeat (2) @(negedge clk);
    chk_outs_zero("rst_h2");
    sel = 1'b1; #1;
    chk_outs_zero("rst_h1");
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // blinky
    wr(5'd0, 16'hE081); wr(5'd1, 16'hE101); wr(5'd2, 16'hE000); wr(5'd3, 16'h0001);
    plen_v = 6'd4; wrap_v = 5'd3; div_v = 24'h000280; pins_v = 32'd1; en_v = 4'd1;
    mi_v = 2'd1;
    run_seq(1'b0, 1'b0, -1);

    // random full program, random length
    for (int k = 0; k < 32; k++) wr(5'(k), 16'($urandom));
    new_cfg(); plen_v = 6'($urandom_range(1, 31));
    run_seq(1'b0, 1'b0, -1);

    // empty program
    new_cfg(); plen_v = 6'd0;
    run_seq(1'b0, 1'b0, -1);

    // over-long program clamps
    new_cfg(); plen_v = 6'd40;
    run_seq(1'b0, 1'b0, -1);

    // start and prog_we while busy are ignored; buffer checked on next load
    new_cfg(); plen_v = 6'd5;
    run_seq(1'b1, 1'b0, -1);
    new_cfg(); plen_v = 6'd6;
    run_seq(1'b0, 1'b0, -1);

    // reset on the first DIV cycle, then a full replay
    new_cfg(); plen_v = 6'd3;
    run_seq(1'b0, 1'b0, 3 * 2 + 2);
    new_cfg(); plen_v = 6'd3;
    run_seq(1'b0, 1'b0, -1);

    // HOLD=1, back-to-back loads with fresh config each time
    sel = 1'b1;
    new_cfg(); plen_v = 6'($urandom_range(1, 40));
    run_seq(1'b0, 1'b1, -1);
    run_seq(1'b0, 1'b1, -1);
    run_seq(1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
